// File: rtl/shift_frame_loader.sv
// Serializes a parallel frame into the display shift register, MSB first, one step every DIV
// clocks, with a valid/ready handshake toward the frame source.
module shift_frame_loader #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] frame_i,
    input  logic             frame_valid_i,
    output logic             frame_ready_o,
    input  logic             hold_i,
    output logic             shift_en_o,
    output logic             shift_in_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned DivW = $clog2(DIV + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

    typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DivW-1:0]  div_q, div_d;
    logic             shift_en_q, shift_en_d;
    logic             shift_in_q, shift_in_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            cnt_q      <= '0;
            div_q      <= '0;
            shift_en_q <= 1'b0;
            shift_in_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            shift_en_q <= shift_en_d;
            shift_in_q <= shift_in_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        shift_en_d = 1'b0;
        shift_in_d = shift_in_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_valid_i) begin
                    buf_d   = frame_i;
                    cnt_d   = '0;
                    div_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                // HOLD freezes the divider, so every later step slips by one cycle.
                if (!hold_i) begin
                    if (div_q == DivLast) begin
                        shift_en_d = 1'b1;
                        shift_in_d = buf_q[WIDTH-1];
                        buf_d      = {buf_q[WIDTH-2:0], 1'b0};
                        cnt_d      = cnt_q + 1'b1;
                        div_d      = '0;
                        if (cnt_q == CntLast) begin
                            state_d = StFinish;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign frame_ready_o = (state_q == StIdle);
    assign busy_o        = (state_q == StShift);
    assign shift_en_o    = shift_en_q;
    assign shift_in_o    = shift_in_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_shift_frame_loader.sv
// Self-checking bench: a DIV=1 and a DIV=4 loader, each feeding a behavioural shift register
// whose contents and pulse timing are compared against arithmetic expectations.
module tb_shift_frame_loader;
    localparam int unsigned W = 256;
    localparam int NDUT = 2;

    typedef struct {
        int           d;
        logic [W-1:0] f;
        int           h;
        int           len;
        int           exp_done;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [W-1:0]    frame [NDUT];
    logic [NDUT-1:0] valid, hold, ready, en, sin, busy, done;
    int              cyc = 0;
    int              n_tests = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_frame_loader #(.WIDTH(W), .DIV(1)) u_dut_div1 (
        .clk_i(clk), .rst_i(rst), .frame_i(frame[0]), .frame_valid_i(valid[0]),
        .frame_ready_o(ready[0]), .hold_i(hold[0]), .shift_en_o(en[0]),
        .shift_in_o(sin[0]), .busy_o(busy[0]), .done_o(done[0]));

    shift_frame_loader #(.WIDTH(W), .DIV(4)) u_dut_div4 (
        .clk_i(clk), .rst_i(rst), .frame_i(frame[1]), .frame_valid_i(valid[1]),
        .frame_ready_o(ready[1]), .hold_i(hold[1]), .shift_en_o(en[1]),
        .shift_in_o(sin[1]), .busy_o(busy[1]), .done_o(done[1]));

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_frame();
        logic [W-1:0] r;
        for (int i = 0; i < int'(W) / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Offset of the j-th pulse from the accept edge: j*DIV nominal, pushed back by the whole
    // hold window once the window's first frozen edge (h+1) is not after the nominal edge.
    function automatic int exp_t(int j, int div, int h, int len);
        return j * div + ((len > 0 && j * div >= h + 1) ? len : 0);
    endfunction

    // Called at a negedge; returns the number of the edge that will accept the frame.
    task automatic start(input int d, input logic [W-1:0] f, output int k);
        int guard = 0;
        while (!ready[d] && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("ready before accept", int'(ready[d]), 1);
        frame[d] = f;
        valid[d] = 1'b1;
        k = cyc + 1;
    endtask

    task automatic run_frame(input int d, input logic [W-1:0] f, input int h, input int len,
                             input bit keep_valid, input bit noise, input int exp_done,
                             input string tag, output int k, output int done_cyc);
        int div, pulses, bad_t, rdy_bad, off;
        logic [W-1:0] sr;
        div = (d == 0) ? 1 : 4;
        pulses = 0;
        bad_t = 0;
        rdy_bad = 0;
        sr = '0;
        done_cyc = -1;
        start(d, f, k);
        for (int c = 0; c < int'(W) * div + len + 50; c++) begin
            @(negedge clk);
            off = cyc - k;
            if (en[d]) begin
                pulses++;
                sr = {sr[W-2:0], sin[d]};
                if (off != exp_t(pulses, div, h, len)) bad_t++;
            end
            if (!done[d] && ready[d]) rdy_bad++;
            if (done[d]) begin
                done_cyc = cyc;
                break;
            end
            hold[d] = (len > 0 && off >= h && off < h + len);
            if (noise) begin
                valid[d] = 1'($urandom);
                frame[d] = rand_frame();
            end else if (!keep_valid) begin
                valid[d] = 1'b0;
            end
        end
        hold[d] = 1'b0;
        valid[d] = keep_valid;
        check({tag, " pulse count"}, pulses, W);
        check({tag, " pulse timing errors"}, bad_t, 0);
        check({tag, " done offset"}, done_cyc - k, exp_done);
        check({tag, " ready high while busy"}, rdy_bad, 0);
        check_vec({tag, " register at done"}, sr, f);
    endtask

    vec_t vecs [6];

    initial begin
        int k, kb, dc, dca, cnt, bad;
        logic [W-1:0] fa;
        valid = '0;
        hold = '0;
        frame[0] = '0;
        frame[1] = '0;

        vecs[0] = '{d: 0, f: {1'b1, {(W-2){1'b0}}, 1'b1}, h: 0, len: 0, exp_done: 257};
        vecs[1] = '{d: 1, f: rand_frame(), h: 37, len: 3, exp_done: 1028};
        vecs[2].d = 0;
        vecs[2].f = rand_frame();
        vecs[2].h = $urandom_range(200, 1);
        vecs[2].len = $urandom_range(6, 1);
        vecs[2].exp_done = 256 + vecs[2].len + 1;
        vecs[3].d = 1;
        vecs[3].f = rand_frame();
        vecs[3].h = $urandom_range(900, 1);
        vecs[3].len = $urandom_range(6, 1);
        vecs[3].exp_done = 1024 + vecs[3].len + 1;
        vecs[4] = '{d: 1, f: rand_frame(), h: 0, len: 0, exp_done: 1025};
        vecs[5] = '{d: 0, f: rand_frame(), h: 0, len: 0, exp_done: 257};

        // Reset asserted mid-cycle acts without a clock edge.
        #3 rst = 1'b1;
        #1;
        check("reset shift_en", int'(en), 0);
        check("reset done", int'(done), 0);
        check("reset busy", int'(busy), 0);
        check("reset ready", int'(ready), 3);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (en != 0 || done != 0 || busy != 0 || ready != 2'b11) bad++;
        end
        check("idle outputs stable", bad, 0);

        foreach (vecs[i]) begin
            run_frame(vecs[i].d, vecs[i].f, vecs[i].h, vecs[i].len, 1'b0, 1'b0,
                      vecs[i].exp_done, $sformatf("vec%0d", i), k, dc);
            @(negedge clk);
            check($sformatf("vec%0d done width", i), int'(done[vecs[i].d]), 0);
            check($sformatf("vec%0d ready after", i), int'(ready[vecs[i].d]), 1);
        end

        // Back-to-back frames with FRAME_VALID held high.
        fa = rand_frame();
        run_frame(1, fa, 0, 0, 1'b1, 1'b0, 1025, "b2b A", k, dca);
        run_frame(1, rand_frame(), 0, 0, 1'b0, 1'b0, 1025, "b2b B", kb, dc);
        check("b2b accept edge", kb, dca + 1);
        check("b2b period", kb - k, 4 * 256 + 2);

        // Frame source noise during shifting must not disturb the stream.
        run_frame(0, rand_frame(), 0, 0, 1'b0, 1'b1, 257, "noise", k, dc);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy[0] || !ready[0]) bad++;
        end
        check("noise no extra accept", bad, 0);

        // Reset in the middle of a frame.
        start(0, rand_frame(), k);
        cnt = 0;
        for (int c = 0; c < 400 && cnt < 100; c++) begin
            @(negedge clk);
            valid[0] = 1'b0;
            if (en[0]) cnt++;
        end
        check("pulses before reset", cnt, 100);
        rst = 1'b1;
        #1;
        check("mid reset shift_en", int'(en[0]), 0);
        check("mid reset busy", int'(busy[0]), 0);
        check("mid reset ready", int'(ready[0]), 1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done[0] || en[0]) bad++;
        end
        check("no done after reset", bad, 0);
        run_frame(0, '1, 0, 0, 1'b0, 1'b0, 257, "ones after reset", k, dc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
